// File: rtl/dcache_data_arbiter.sv
// dcache_data_arbiter: shares one data store port between refill line writes, stores and loads,
// with a refill beat buffer and a starvation guard for the load port.
module dcache_data_arbiter #(
  parameter int DATA_WIDTH = 128,
  parameter int NUM_WORDS  = 256,
  parameter int BEAT_WIDTH = 64,
  parameter int MAX_WAIT   = 7,
  localparam int AW     = $clog2(NUM_WORDS),
  localparam int NBEATS = DATA_WIDTH / BEAT_WIDTH,
  localparam int BW8    = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  rf_valid_i,
  output logic                  rf_ready_o,
  input  logic [AW-1:0]         rf_addr_i,
  input  logic [BEAT_WIDTH-1:0] rf_data_i,
  output logic                  rf_done_o,
  input  logic                  st_req_i,
  output logic                  st_gnt_o,
  input  logic [AW-1:0]         st_addr_i,
  input  logic [BW8-1:0]        st_be_i,
  input  logic [DATA_WIDTH-1:0] st_data_i,
  input  logic                  ld_req_i,
  output logic                  ld_gnt_o,
  input  logic [AW-1:0]         ld_addr_i,
  output logic                  ld_rvalid_o,
  output logic [DATA_WIDTH-1:0] ld_rdata_o,
  output logic                  ds_en_o,
  output logic                  ds_we_o,
  output logic [BW8-1:0]        ds_be_o,
  output logic [AW-1:0]         ds_addr_o,
  output logic [DATA_WIDTH-1:0] ds_wdata_o,
  input  logic [DATA_WIDTH-1:0] ds_rdata_i
);
  localparam int CW = $clog2(NBEATS);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);
  localparam logic [CW-1:0] LAST = CW'(NBEATS - 1);
  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;
  state_t                state_q;
  logic [CW-1:0]         cnt_q;
  logic [WW-1:0]         wait_q;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] line_q;
  logic [AW-1:0]         addr_q;
  logic                  wr_g, starved, acc, last;
  // Grants are combinational and forced low during reset so every output reads 0.
  always_comb begin
    wr_g        = !rst_i && state_q == WRITE;
    starved     = wait_q == WMAX;
    rf_ready_o  = !rst_i && state_q != WRITE;
    acc         = rf_valid_i && rf_ready_o;
    last        = cnt_q == LAST;
    ld_gnt_o    = !rst_i && ld_req_i && !wr_g && (starved || !st_req_i);
    st_gnt_o    = !rst_i && st_req_i && !wr_g && !ld_gnt_o;
    rf_done_o   = wr_g;
    ds_en_o     = wr_g || st_gnt_o || ld_gnt_o;
    ds_we_o     = wr_g || st_gnt_o;
    ds_be_o     = wr_g ? '1 : st_gnt_o ? st_be_i : '0;
    ds_addr_o   = wr_g ? addr_q : st_gnt_o ? st_addr_i : ld_gnt_o ? ld_addr_i : '0;
    ds_wdata_o  = wr_g ? line_q : st_gnt_o ? st_data_i : '0;
    ld_rvalid_o = rvalid_q;
    ld_rdata_o  = rvalid_q ? ds_rdata_i : '0;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wait_q   <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= ld_gnt_o;
      wait_q   <= (!ld_req_i || ld_gnt_o) ? '0 : starved ? wait_q : wait_q + 1'b1;
      if (state_q == WRITE) begin
        state_q <= IDLE;
      end else if (acc) begin
        cnt_q   <= last ? '0 : cnt_q + 1'b1;
        state_q <= last ? WRITE : FILL;
      end
    end
  end
  // Line buffer and refill index are data only; they survive reset untouched.
  always_ff @(posedge clk_i) begin
    if (acc) begin
      line_q[int'(cnt_q)*BEAT_WIDTH +: BEAT_WIDTH] <= rf_data_i;
      if (cnt_q == '0) addr_q <= rf_addr_i;
    end
  end
endmodule

// File: doc/dcache_data_arbiter.md
DCACHE_DATA_ARBITER -- requirements
Module: dcache_data_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128, cache line width in bits.
REQ-002 SHALL have parameter NUM_WORDS, default 256, data store depth in lines; AW = $clog2(NUM_WORDS).
REQ-003 SHALL have parameter BEAT_WIDTH, default 64, refill beat width; NBEATS = DATA_WIDTH/BEAT_WIDTH, at least 2.
REQ-004 SHALL have parameter MAX_WAIT, default 7, starvation limit for the load port in cycles.
REQ-005 SHALL have ports:
- clk_i  in  1  sole clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- rf_valid_i / rf_ready_o  in/out  1  refill beat handshake.
- rf_addr_i  in  AW  refill line index, sampled on the first beat.
- rf_data_i  in  BEAT_WIDTH  refill beat, lowest beat first.
- rf_done_o  out  1  one-cycle pulse when the refilled line is written.
- st_req_i / st_gnt_o  in/out  1  store request and grant.
- st_addr_i  in  AW  store line index.
- st_be_i  in  DATA_WIDTH/8  store byte enables.
- st_data_i  in  DATA_WIDTH  store data.
- ld_req_i / ld_gnt_o  in/out  1  load request and grant.
- ld_addr_i  in  AW  load line index.
- ld_rvalid_o  out  1  load data valid.
- ld_rdata_o  out  DATA_WIDTH  load data.
- ds_en_o, ds_we_o  out  1  data store enable and write enable.
- ds_be_o  out  DATA_WIDTH/8  data store byte enables.
- ds_addr_o  out  AW  data store line index.
- ds_wdata_o  out  DATA_WIDTH  data store write data.
- ds_rdata_i  in  DATA_WIDTH  data store read data, valid one cycle after a read.

Function
REQ-006 SHALL accept a refill beat when rf_valid_i and rf_ready_o are both high in the same cycle.
REQ-007 SHALL store accepted beats in an internal line buffer; beat k occupies bits [k*BEAT_WIDTH +: BEAT_WIDTH].
REQ-008 SHALL count accepted beats with a beat counter; after beat NBEATS-1 the counter wraps to 0 and the buffer goes FULL.
REQ-009 SHALL drive rf_ready_o low while the buffer is FULL, and high otherwise.
REQ-010 SHALL run a three-state FSM: IDLE, FILL and WRITE.
- IDLE to FILL on the first accepted beat.
- FILL to WRITE when the last beat is accepted.
- WRITE to IDLE in the cycle the line write is issued.
REQ-011 SHALL give each data store slot to at most one grant per cycle, in this priority order:
- first, the buffered refill line while in WRITE;
- second, a starved load;
- third, a store;
- last, a load.
REQ-012 SHALL, for the refill write, drive ds_en_o=1, ds_we_o=1, ds_be_o all ones, ds_addr_o = latched refill index, ds_wdata_o = buffer, and pulse rf_done_o in that same cycle.
REQ-013 SHALL, for a store grant, drive ds_en_o=1, ds_we_o=1, ds_be_o=st_be_i, ds_addr_o=st_addr_i, ds_wdata_o=st_data_i and st_gnt_o=1 in the same cycle as the request (combinational grant).
REQ-014 SHALL, for a load grant, drive ds_en_o=1, ds_we_o=0, ds_be_o=0, ds_addr_o=ld_addr_i and ld_gnt_o=1.
REQ-015 SHALL assert ld_rvalid_o exactly one cycle after a load grant, with ld_rdata_o=ds_rdata_i; ld_rvalid_o SHALL be 0 in all other cycles.
REQ-016 SHALL drive ds_en_o=0 and hold ds_we_o, ds_be_o, ds_addr_o and ds_wdata_o at 0 when nothing is granted.
REQ-017 SHALL run a wait counter: +1 each cycle ld_req_i is high and not granted, reset to 0 on a load grant or when ld_req_i is low, saturating at MAX_WAIT.
REQ-018 SHALL treat the load as starved while the wait counter equals MAX_WAIT; a starved load beats a store but not the refill write.
REQ-019 SHALL allow a beat to be accepted in the same cycle a store or load is granted; beat acceptance never blocks the data store.
REQ-020 SHALL, when the last beat is accepted, first offer the refill write in the following cycle.
REQ-021 SHALL keep each requester's request signals stable until granted; the arbiter does not buffer store or load requests.

Reset
REQ-022 SHALL, while rst_i is high, set the FSM to IDLE and the beat counter, wait counter and ld_rvalid pipeline register to 0, independent of clk_i.
REQ-023 SHALL, while rst_i is high, hold every output at 0: rf_ready_o, rf_done_o, st_gnt_o, ld_gnt_o, ld_rvalid_o, ld_rdata_o and all ds_* outputs.
REQ-024 SHALL discard a partial refill line when reset is asserted mid-refill; after reset the refill port starts again from beat 0.
REQ-025 SHALL not clear the line buffer contents on reset.

Verification
REQ-026 SHALL be covered by a single load: ld_addr_i=5, ds_rdata_i=0xA5.. in the next cycle -> ld_gnt_o high in cycle 0, ld_rvalid_o high in cycle 1 with ld_rdata_o=0xA5.., ds_we_o=0.
REQ-027 SHALL be covered by a two-beat refill: beats 0x1111, then 0x2222 to index 9 -> in the cycle after the last beat, ds_we_o=1, ds_be_o all ones, ds_wdata_o={0x2222,0x1111}, rf_done_o pulses; rf_ready_o is low for that one cycle.
REQ-028 SHALL be covered by a simultaneous store and load with MAX_WAIT=7: both held high -> store granted for 7 cycles, then the load is granted in cycle 7, then the store resumes.
REQ-029 SHALL be covered by a refill write, a store and a starved load all pending -> the refill write is granted first, then the load, then the store.
REQ-030 SHALL be covered by reset asserted after refill beat 0 -> all outputs 0 immediately; after reset is released, the next beat is treated as beat 0 and no data store write occurs from the discarded beat.
REQ-031 SHALL be covered by an idle bus with no requests -> ds_en_o=0 in every cycle and no grants.
